// File: rtl/trace_retire_buffer.sv
// Normalises one retirement event per cycle and queues it for the instruction tracer.
// Latency: 1 cycle from ret_valid_i to trc_valid_o; head is fall-through from registered storage.
// Backpressure: the core is never stalled; events arriving while full (and not popping) are dropped and counted.
module trace_retire_buffer #(
    parameter int DEPTH  = 8,
    parameter int CYC_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ret_valid_i,
    input  logic [31:0]       ret_pc_i,
    input  logic [31:0]       ret_insn_i,
    input  logic [4:0]        ret_rd_addr_i,
    input  logic              ret_rd_we_i,
    input  logic [31:0]       ret_rd_wdata_i,
    input  logic [31:0]       ret_mem_addr_i,
    input  logic              ret_mem_re_i,
    input  logic              ret_mem_we_i,
    input  logic [31:0]       ret_mem_data_i,
    input  logic              clear_i,
    output logic              trc_valid_o,
    input  logic              trc_ready_i,
    output logic [31:0]       trc_pc_o,
    output logic [31:0]       trc_insn_o,
    output logic              trc_compressed_o,
    output logic [4:0]        trc_rd_addr_o,
    output logic              trc_rd_we_o,
    output logic [31:0]       trc_rd_wdata_o,
    output logic [31:0]       trc_mem_addr_o,
    output logic              trc_mem_re_o,
    output logic              trc_mem_we_o,
    output logic [31:0]       trc_mem_data_o,
    output logic [CYC_W-1:0]  trc_cycle_o,
    output logic [CYC_W-1:0]  trc_seq_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      insn;
        logic             compressed;
        logic [4:0]       rd_addr;
        logic             rd_we;
        logic [31:0]      rd_wdata;
        logic [31:0]      mem_addr;
        logic             mem_re;
        logic             mem_we;
        logic [31:0]      mem_data;
        logic [CYC_W-1:0] cycle;
        logic [CYC_W-1:0] seq;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            push_ent;
    entry_t            head_ent;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [CYC_W-1:0]  seq_cnt;
    logic              almost_full_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && trc_ready_i;
    assign push  = ret_valid_i && (!full || pop);
    assign drop  = ret_valid_i && full && !pop;

    // Build the normalised entry: compressed detect, x0 write squash, unused memory fields zeroed.
    always_comb begin
        push_ent            = '0;
        push_ent.pc         = ret_pc_i;
        push_ent.rd_addr    = ret_rd_addr_i;
        push_ent.mem_re     = ret_mem_re_i;
        push_ent.mem_we     = ret_mem_we_i;
        push_ent.cycle      = cyc_cnt;
        push_ent.seq        = seq_cnt;
        if (ret_insn_i[1:0] != 2'b11) begin
            push_ent.compressed = 1'b1;
            push_ent.insn       = {16'h0000, ret_insn_i[15:0]};
        end else begin
            push_ent.compressed = 1'b0;
            push_ent.insn       = ret_insn_i;
        end
        push_ent.rd_we = ret_rd_we_i && (ret_rd_addr_i != 5'd0);
        if (push_ent.rd_we) begin
            push_ent.rd_wdata = ret_rd_wdata_i;
        end
        if (ret_mem_re_i || ret_mem_we_i) begin
            push_ent.mem_addr = ret_mem_addr_i;
            push_ent.mem_data = ret_mem_data_i;
        end
    end

    // Occupancy after this cycle's push/pop; drives the registered almost-full flag.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Entry storage is not reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= push_ent;
        end
    end

    // Pointers, occupancy and almost-full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            almost_full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count         <= count_next;
            almost_full_q <= (count_next >= CW'(DEPTH - 1));
        end
    end

    // Free-running cycle stamp and per-accepted-event sequence number.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
            seq_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
            if (push) seq_cnt <= seq_cnt + CYC_W'(1);
        end
    end

    // Sticky overflow and saturating drop count; a drop coinciding with clear counts as the first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            overflow_q <= drop;
            drop_cnt_q <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    assign head_ent         = empty ? '0 : mem_q[rd_ptr];
    assign trc_valid_o      = !empty;
    assign trc_pc_o         = head_ent.pc;
    assign trc_insn_o       = head_ent.insn;
    assign trc_compressed_o = head_ent.compressed;
    assign trc_rd_addr_o    = head_ent.rd_addr;
    assign trc_rd_we_o      = head_ent.rd_we;
    assign trc_rd_wdata_o   = head_ent.rd_wdata;
    assign trc_mem_addr_o   = head_ent.mem_addr;
    assign trc_mem_re_o     = head_ent.mem_re;
    assign trc_mem_we_o     = head_ent.mem_we;
    assign trc_mem_data_o   = head_ent.mem_data;
    assign trc_cycle_o      = head_ent.cycle;
    assign trc_seq_o        = head_ent.seq;
    assign almost_full_o    = almost_full_q;
    assign overflow_o       = overflow_q;
    assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_trace_retire_buffer.sv
// Scoreboard bench for trace_retire_buffer: directed stimulus pushes expectations, a monitor pops on handshakes.
// Latency: checks one cycle after push; monitor samples on the falling edge.
// Backpressure: trc_ready_i driven by the stimulus to exercise hold, overflow and full+pop cases.
module tb_trace_retire_buffer;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        compressed;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic        mem_re;
        logic        mem_we;
        logic [31:0] mem_data;
        logic [31:0] cycle;
        logic [31:0] seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ret_valid_i = 1'b0;
    logic [31:0] ret_pc_i = '0;
    logic [31:0] ret_insn_i = '0;
    logic [4:0]  ret_rd_addr_i = '0;
    logic        ret_rd_we_i = 1'b0;
    logic [31:0] ret_rd_wdata_i = '0;
    logic [31:0] ret_mem_addr_i = '0;
    logic        ret_mem_re_i = 1'b0;
    logic        ret_mem_we_i = 1'b0;
    logic [31:0] ret_mem_data_i = '0;
    logic        clear_i = 1'b0;
    logic        trc_valid_o;
    logic        trc_ready_i = 1'b0;
    logic [31:0] trc_pc_o;
    logic [31:0] trc_insn_o;
    logic        trc_compressed_o;
    logic [4:0]  trc_rd_addr_o;
    logic        trc_rd_we_o;
    logic [31:0] trc_rd_wdata_o;
    logic [31:0] trc_mem_addr_o;
    logic        trc_mem_re_o;
    logic        trc_mem_we_o;
    logic [31:0] trc_mem_data_o;
    logic [31:0] trc_cycle_o;
    logic [31:0] trc_seq_o;
    logic        almost_full_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] cyc_model;
    logic [31:0] seq_model = '0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_seq;

    trace_retire_buffer #(.DEPTH(DEPTH), .CYC_W(32), .DROP_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_insn_i(ret_insn_i),
        .ret_rd_addr_i(ret_rd_addr_i), .ret_rd_we_i(ret_rd_we_i), .ret_rd_wdata_i(ret_rd_wdata_i),
        .ret_mem_addr_i(ret_mem_addr_i), .ret_mem_re_i(ret_mem_re_i), .ret_mem_we_i(ret_mem_we_i),
        .ret_mem_data_i(ret_mem_data_i), .clear_i(clear_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_pc_o(trc_pc_o),
        .trc_insn_o(trc_insn_o), .trc_compressed_o(trc_compressed_o), .trc_rd_addr_o(trc_rd_addr_o),
        .trc_rd_we_o(trc_rd_we_o), .trc_rd_wdata_o(trc_rd_wdata_o), .trc_mem_addr_o(trc_mem_addr_o),
        .trc_mem_re_o(trc_mem_re_o), .trc_mem_we_o(trc_mem_we_o), .trc_mem_data_o(trc_mem_data_o),
        .trc_cycle_o(trc_cycle_o), .trc_seq_o(trc_seq_o), .almost_full_o(almost_full_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_model <= '0;
        else          cyc_model <= cyc_model + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one retirement for one cycle; when acc is set the normalised expectation is queued.
    task automatic send(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic rwe, input logic [31:0] wd, input logic [31:0] ma,
                        input logic re, input logic mwe, input logic [31:0] md, input bit acc);
        exp_t e;
        ret_valid_i    = 1'b1;
        ret_pc_i       = pc;
        ret_insn_i     = insn;
        ret_rd_addr_i  = rd;
        ret_rd_we_i    = rwe;
        ret_rd_wdata_i = wd;
        ret_mem_addr_i = ma;
        ret_mem_re_i   = re;
        ret_mem_we_i   = mwe;
        ret_mem_data_i = md;
        if (acc) begin
            e.pc         = pc;
            e.compressed = (insn[1:0] != 2'b11);
            e.insn       = e.compressed ? {16'h0000, insn[15:0]} : insn;
            e.rd_addr    = rd;
            e.rd_we      = rwe && (rd != 5'd0);
            e.rd_wdata   = e.rd_we ? wd : 32'h0;
            e.mem_re     = re;
            e.mem_we     = mwe;
            e.mem_addr   = (re || mwe) ? ma : 32'h0;
            e.mem_data   = (re || mwe) ? md : 32'h0;
            e.cycle      = cyc_model;
            e.seq        = seq_model;
            seq_model    = seq_model + 32'd1;
            sb.push_back(e);
        end
        step();
        ret_valid_i = 1'b0;
    endtask

    // Monitor: compare the head against the scoreboard on each handshake; check holds while stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && trc_valid_o) begin
                chk("hold_pc", trc_pc_o, prev_pc);
                chk("hold_seq", trc_seq_o, prev_seq);
            end
            if (trc_valid_o && trc_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output_seq", trc_seq_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("pc", trc_pc_o, sb[0].pc);
                    chk("insn", trc_insn_o, sb[0].insn);
                    chk("compressed", trc_compressed_o, sb[0].compressed);
                    chk("rd_addr", trc_rd_addr_o, sb[0].rd_addr);
                    chk("rd_we", trc_rd_we_o, sb[0].rd_we);
                    chk("rd_wdata", trc_rd_wdata_o, sb[0].rd_wdata);
                    chk("mem_flags", {trc_mem_re_o, trc_mem_we_o}, {sb[0].mem_re, sb[0].mem_we});
                    chk("mem_addr", trc_mem_addr_o, sb[0].mem_addr);
                    chk("mem_data", trc_mem_data_o, sb[0].mem_data);
                    chk("cycle", trc_cycle_o, sb[0].cycle);
                    chk("seq", trc_seq_o, sb[0].seq);
                    void'(sb.pop_front());
                end
            end
            prev_hold = trc_valid_o && !trc_ready_i;
            prev_pc   = trc_pc_o;
            prev_seq  = trc_seq_o;
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_valid", trc_valid_o, 0);
        chk("rst_pc", trc_pc_o, 0);
        chk("rst_seq", trc_seq_o, 0);
        chk("rst_af", almost_full_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Single push at cycle 3 then single-cycle latency
        trc_ready_i = 1'b1;
        repeat (3) step();
        chk("t1_cycle_model", cyc_model, 3);
        chk("t1_empty_before", trc_valid_o, 0);
        send(32'h8000_0000, 32'h0050_0093, 5'd1, 1'b1, 32'd5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_valid_latency1", trc_valid_o, 1);
        step();

        // Normalisation cases
        send(32'h8000_0004, 32'hDEAD_4505, 5'd10, 1'b1, 32'd1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        send(32'h8000_0006, 32'h0000_0013, 5'd0, 1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        send(32'h8000_000A, 32'h0041_2283, 5'd5, 1'b1, 32'hCAFE, 32'h1000_0004, 1'b1, 1'b0, 32'hCAFE, 1'b1);
        send(32'h8000_000E, 32'h0000_0033, 5'd3, 1'b0, 32'h77, 32'hABCD, 1'b0, 1'b0, 32'h99, 1'b1);
        send(32'h8000_0012, 32'h00B5_2023, 5'd0, 1'b0, 32'h0, 32'h2000_0000, 1'b0, 1'b1, 32'h55AA, 1'b1);
        repeat (3) step();

        // Fresh start: overflow with ready held low
        reset_n = 1'b0;
        #3 reset_n = 1'b1;
        seq_model = '0;
        trc_ready_i = 1'b0;
        step();
        for (int i = 1; i <= DEPTH + 3; i++) begin
            send(32'h9000_0000 + 32'(4 * i), 32'h0000_0013, 5'd2, 1'b1, 32'(i), 32'h0, 1'b0, 1'b0, 32'h0, i <= DEPTH);
            chk("t3_af", almost_full_o, i >= DEPTH - 1);
            chk("t3_drop_cnt", drop_cnt_o, (i > DEPTH) ? i - DEPTH : 0);
        end
        chk("t3_overflow", overflow_o, 1);
        chk("t3_drop3", drop_cnt_o, 3);
        trc_ready_i = 1'b1;
        repeat (10) step();
        send(32'h9100_0000, 32'h0000_0013, 5'd1, 1'b1, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        trc_ready_i = 1'b0;
        repeat (2) step();

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < DEPTH; i++)
            send(32'hA000_0000 + 32'(4 * i), 32'h0000_0013, 5'd4, 1'b1, 32'(i), 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        trc_ready_i = 1'b1;
        send(32'hA100_0000, 32'h0000_0013, 5'd4, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        trc_ready_i = 1'b0;
        chk("t4_no_drop", drop_cnt_o, 3);
        chk("t4_af", almost_full_o, 1);
        chk("t4_head_seq", trc_seq_o, 10);
        send(32'hA200_0000, 32'h0000_0013, 5'd4, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_still_full_drop", drop_cnt_o, 4);
        trc_ready_i = 1'b1;
        repeat (10) step();

        // Saturation and clear
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t5_clear_ovf", overflow_o, 0);
        chk("t5_clear_cnt", drop_cnt_o, 0);
        trc_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(32'hB000_0000 + 32'(4 * i), 32'h0000_0001, 5'd6, 1'b1, 32'(i), 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        ret_valid_i = 1'b1;
        repeat (65537) step();
        ret_valid_i = 1'b0;
        chk("t5_saturated", drop_cnt_o, 16'hFFFF);
        send(32'hB100_0000, 32'h0000_0013, 5'd6, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_stay_saturated", drop_cnt_o, 16'hFFFF);
        clear_i = 1'b1;
        send(32'hB200_0000, 32'h0000_0013, 5'd6, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        clear_i = 1'b0;
        chk("t5_clr_drop_ovf", overflow_o, 1);
        chk("t5_clr_drop_cnt", drop_cnt_o, 1);
        trc_ready_i = 1'b1;
        repeat (10) step();
        chk("t5_af_drained", almost_full_o, 0);

        // Asynchronous reset mid-stream flushes the queue
        trc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            send(32'hC000_0000 + 32'(4 * i), 32'h0000_0013, 5'd7, 1'b1, 32'(i), 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_valid_before", trc_valid_o, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_async_flush", trc_valid_o, 0);
        chk("t6_rst_ovf", overflow_o, 0);
        chk("t6_rst_cnt", drop_cnt_o, 0);
        sb.delete();
        seq_model = '0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        send(32'hD000_0000, 32'h0000_0013, 5'd8, 1'b1, 32'h42, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_small_cycle", trc_cycle_o < 32'd8, 1);
        trc_ready_i = 1'b1;
        repeat (4) step();

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_retire_buffer.md
Name: trace_retire_buffer

Overview:
- Capture stage directly upstream of the instruction tracer.
- Samples one retirement event per cycle from the core writeback/commit point and normalises it: detects compressed encodings, squashes x0 writes, and stamps each event with a cycle time and a sequence number.
- Queues events in a FIFO and hands them to the tracer's decode/print logic over a valid/ready handshake.
- The core is never back-pressured: events that arrive while the FIFO is full are dropped and counted.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CYC_W, 32, width of cycle stamp and sequence counter.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- ret_valid_i  in  1  one instruction retires this cycle
- ret_pc_i  in  32  PC of retiring instruction
- ret_insn_i  in  32  raw instruction word (upper half don't-care if compressed)
- ret_rd_addr_i  in  5  destination register
- ret_rd_we_i  in  1  register write enable
- ret_rd_wdata_i  in  32  register write data
- ret_mem_addr_i  in  32  load/store address
- ret_mem_re_i  in  1  instruction performed a load
- ret_mem_we_i  in  1  instruction performed a store
- ret_mem_data_i  in  32  load data or store data
- clear_i  in  1  synchronous clear of overflow_o and drop_cnt_o
- trc_valid_o  out  1  head entry valid toward tracer
- trc_ready_i  in  1  tracer consumes head entry
- trc_pc_o  out  32  head entry PC
- trc_insn_o  out  32  normalised instruction
- trc_compressed_o  out  1  head entry is a 16-bit instruction
- trc_rd_addr_o  out  5  head entry destination register
- trc_rd_we_o  out  1  head entry register write enable
- trc_rd_wdata_o  out  32  head entry register write data
- trc_mem_addr_o  out  32  head entry load/store address
- trc_mem_re_o  out  1  head entry load flag
- trc_mem_we_o  out  1  head entry store flag
- trc_mem_data_o  out  32  head entry load/store data
- trc_cycle_o  out  CYC_W  cycle stamp of head entry
- trc_seq_o  out  CYC_W  retire sequence number of head entry
- almost_full_o  out  1  occupancy ≥ DEPTH-1
- overflow_o  out  1  sticky: at least one event dropped
- drop_cnt_o  out  DROP_W  number of dropped events, saturating

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values:
  - all trc_* outputs, almost_full_o, overflow_o, drop_cnt_o = 0;
  - FIFO empty; cycle counter = 0; sequence counter = 0.
- Cycle counter:
  - increments by 1 every clk edge after reset release;
  - wraps modulo 2^CYC_W;
  - a pushed entry stores the counter value present in its push cycle.
- Normalisation, applied at push:
  - if ret_insn_i[1:0] != 2'b11: compressed=1, insn = {16'h0, ret_insn_i[15:0]};
  - otherwise compressed=0 and insn is unchanged;
  - rd_we is stored as ret_rd_we_i && (ret_rd_addr_i != 0); when it is 0, rd_wdata is stored as 0;
  - mem_addr and mem_data are stored as 0 when both mem_re and mem_we are 0.
- Push:
  - occurs when ret_valid_i && (!full || (trc_valid_o && trc_ready_i));
  - a full FIFO with a simultaneous pop accepts the new event;
  - each accepted push takes the current sequence number, then the sequence number increments, wrapping.
- Drop:
  - occurs when ret_valid_i && full && !(trc_valid_o && trc_ready_i);
  - sets overflow_o; drop_cnt_o increments and saturates at all-ones;
  - the sequence number is not advanced.
- Clear:
  - clear_i zeroes overflow_o and drop_cnt_o;
  - if a drop occurs in the same cycle, the result is overflow_o=1 and drop_cnt_o=1.
- Output handshake:
  - trc_valid_o = FIFO non-empty;
  - outputs are driven from the head entry, first-word fall-through from registered storage;
  - a push into an empty FIFO is visible on trc_valid_o on the next cycle (latency 1); no combinational path from ret_* to trc_*;
  - pop on trc_valid_o && trc_ready_i; trc_ready_i is ignored while empty;
  - while trc_valid_o && !trc_ready_i, all trc_* outputs are held stable.
- Ordering: strict FIFO order; read and write pointers wrap modulo DEPTH; occupancy counter is DEPTH+1 valued.
- almost_full_o is registered and reflects occupancy after the current cycle's push/pop.
- Asserting reset_n low mid-stream flushes all entries immediately and resets all counters.

Test Plan:
- Reset, then a single push of pc=0x8000_0000, insn=0x0050_0093 (addi x1,x0,5), rd_we=1, wdata=5 at cycle 3 → next cycle trc_valid_o=1, trc_cycle_o=3, trc_seq_o=0, trc_compressed_o=0; pops with ready=1.
- Push insn=0xDEAD_4505 (c.li x10,1) → trc_insn_o=0x0000_4505, trc_compressed_o=1. Push rd_addr=0, rd_we=1, wdata=0x1234 → trc_rd_we_o=0, trc_rd_wdata_o=0.
- Hold trc_ready_i=0 and push DEPTH+3 (=11) events → first 8 queued with seq 0..7; overflow_o=1, drop_cnt_o=3; almost_full_o=1 once occupancy reaches 7. Release ready → entries drain in order with seq 0..7, and the next accepted push gets seq 8.
- FIFO full, then ret_valid_i=1 and trc_ready_i=1 in the same cycle → head popped, new event accepted, occupancy stays 8, no drop.
- Force drop_cnt_o to 0xFFFF via repeated drops → further drops keep 0xFFFF. clear_i pulsed together with a drop → overflow_o=1, drop_cnt_o=1.
- With 5 entries queued, assert reset_n=0 asynchronously mid-cycle → trc_valid_o=0 immediately; after release the first push reports trc_seq_o=0 and a small trc_cycle_o.
